// File: rtl/serial_in_port_pkg.sv
// Shared definitions for the serial input port: RX FSM state encoding,
// default divider/FIFO sizing and the even-parity helper used by 8E1 frames.
package serial_in_port_pkg;

    localparam int unsigned SIN_BAUD_DIV = 16;
    localparam int unsigned SIN_FIFO_AW  = 3;

    typedef enum logic [2:0] {
        SIN_ST_IDLE   = 3'd0,
        SIN_ST_START  = 3'd1,
        SIN_ST_DATA   = 3'd2,
        SIN_ST_PARITY = 3'd3,
        SIN_ST_STOP   = 3'd4
    } sin_state_t;

    // Parity bit that makes the total count of ones in data+parity even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/serial_in_port_if.sv
// Serial line plus CPU INP/FGI handshake bundle of the serial input port.
// master = the port itself, slave = the CPU/line side.
interface serial_in_port_if;
    logic       uart_rxd;
    logic       fgi;
    logic       fgi_bsy;
    logic [7:0] inpr;
    logic       rx_err;
    logic       rx_ovf;

    modport master (
        input  uart_rxd,
        input  fgi,
        output fgi_bsy,
        output inpr,
        output rx_err,
        output rx_ovf
    );

    modport slave (
        output uart_rxd,
        output fgi,
        input  fgi_bsy,
        input  inpr,
        input  rx_err,
        input  rx_ovf
    );
endinterface

// File: rtl/serial_in_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and first-word fall-through
// output. A push while full is honoured only when a pop happens in the same cycle.
module serial_in_fifo
    import serial_in_port_pkg::*;
#(
    parameter int unsigned FIFO_AW = SIN_FIFO_AW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[FIFO_AW-1:0]];

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= din;
        end
    end

    // Read/write pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/serial_in_port.sv
// Serial input port: 8N1 UART receiver feeding a byte FIFO, drained one byte
// at a time into the CPU input register with the FGI set-strobe handshake.
// Define SERIAL_IN_PARITY_EN to receive 8E1 frames (adds the PARITY state).
module serial_in_port
    import serial_in_port_pkg::*;
#(
    parameter int unsigned BAUD_DIV = SIN_BAUD_DIV,
    parameter int unsigned FIFO_AW  = SIN_FIFO_AW
) (
    input  logic             clk,
    input  logic             rst,
    serial_in_port_if.master bus
);

    localparam int unsigned     CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

    sin_state_t       state, state_nxt;
    logic             rxd_m, rxd_s, rxd_q;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             byte_done, err_set, ovf_set;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;
    logic             deliver;
    logic             wait_ack;
    logic             fgi_bsy_r;
    logic [7:0]       inpr_r;
    logic             rx_err_r, rx_ovf_r;
`ifdef SERIAL_IN_PARITY_EN
    logic             par_bad;
`endif

    assign fall    = rxd_q & ~rxd_s;
    assign tick    = (cnt == '0);
    assign deliver = !fifo_empty && !bus.fgi && !wait_ack;
    assign ovf_set = byte_done && fifo_full && !deliver;

    // Two-stage synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_q <= 1'b1;
        end else begin
            rxd_m <= bus.uart_rxd;
            rxd_s <= rxd_m;
            rxd_q <= rxd_s;
        end
    end

    // RX FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SIN_ST_IDLE;
        else     state <= state_nxt;
    end

    // RX FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            SIN_ST_IDLE:  if (fall) state_nxt = SIN_ST_START;
            SIN_ST_START: if (tick) state_nxt = rxd_s ? SIN_ST_IDLE : SIN_ST_DATA;
            SIN_ST_DATA:  if (tick && bit_idx == 3'd7) begin
`ifdef SERIAL_IN_PARITY_EN
                state_nxt = SIN_ST_PARITY;
`else
                state_nxt = SIN_ST_STOP;
`endif
            end
`ifdef SERIAL_IN_PARITY_EN
            SIN_ST_PARITY: if (tick) state_nxt = SIN_ST_STOP;
`endif
            SIN_ST_STOP:  if (tick) state_nxt = SIN_ST_IDLE;
            default:      state_nxt = SIN_ST_IDLE;
        endcase
    end

    // RX FSM outputs: byte completion and error strobes on the sample cycle.
    always_comb begin
        byte_done = 1'b0;
        err_set   = 1'b0;
        if (tick) begin
            case (state)
`ifdef SERIAL_IN_PARITY_EN
                SIN_ST_PARITY: err_set = (rxd_s != even_parity(shreg));
                SIN_ST_STOP: begin
                    byte_done = rxd_s && !par_bad;
                    err_set   = !rxd_s;
                end
`else
                SIN_ST_STOP: begin
                    byte_done = rxd_s;
                    err_set   = !rxd_s;
                end
`endif
                default: ;
            endcase
        end
    end

    // Bit-period divider, bit index and shift register. The divider is held
    // at the half-bit reload while idle, so it restarts on every start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= CNT_HALF;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == SIN_ST_IDLE) cnt <= CNT_HALF;
            else if (tick)            cnt <= CNT_FULL;
            else                      cnt <= cnt - 1'b1;
            if (state == SIN_ST_START) bit_idx <= '0;
            else if (state == SIN_ST_DATA && tick) bit_idx <= bit_idx + 3'd1;
            if (state == SIN_ST_DATA && tick) shreg <= {rxd_s, shreg[7:1]};
        end
    end

`ifdef SERIAL_IN_PARITY_EN
    // Remember a parity mismatch until the stop bit decides the byte's fate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 par_bad <= 1'b0;
        else if (state == SIN_ST_IDLE)           par_bad <= 1'b0;
        else if (state == SIN_ST_PARITY && tick) par_bad <= (rxd_s != even_parity(shreg));
    end
`endif

    // Sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_err_r <= 1'b0;
            rx_ovf_r <= 1'b0;
        end else begin
            if (err_set) rx_err_r <= 1'b1;
            if (ovf_set) rx_ovf_r <= 1'b1;
        end
    end

    // CPU handshake: pop into inpr with a one-cycle low strobe, then wait for
    // FGI to be seen set before another delivery may start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fgi_bsy_r <= 1'b1;
            inpr_r    <= '0;
            wait_ack  <= 1'b0;
        end else begin
            fgi_bsy_r <= !deliver;
            if (deliver) begin
                inpr_r   <= fifo_dout;
                wait_ack <= 1'b1;
            end else if (bus.fgi) begin
                wait_ack <= 1'b0;
            end
        end
    end

    serial_in_fifo #(
        .FIFO_AW(FIFO_AW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (byte_done),
        .din  (shreg),
        .pop  (deliver),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign bus.fgi_bsy = fgi_bsy_r;
    assign bus.inpr    = inpr_r;
    assign bus.rx_err  = rx_err_r;
    assign bus.rx_ovf  = rx_ovf_r;

endmodule

// File: tb/tb_serial_in_port.sv
// Bench for serial_in_port: a UART line driver, a CPU responder acknowledging
// each strobe, and a byte-queue model of what the CPU should receive.
module tb_serial_in_port;

    localparam int BAUD = 16;
    localparam int AW   = 3;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;
    logic hold;
    int   checks;
    int   failures;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic exp_err;
    logic exp_ovf;

    serial_in_port_if sif ();

    serial_in_port #(
        .BAUD_DIV(BAUD),
        .FIFO_AW (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // CPU side: take the byte on each strobe, set FGI, clear it after a
    // random think time unless the test is holding FGI high.
    initial begin
        sif.fgi = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && sif.fgi_bsy === 1'b0) begin
                got_q.push_back(sif.inpr);
                sif.fgi = 1'b1;
                @(negedge clk);
                chk("strobe_width", {31'b0, sif.fgi_bsy}, 32'd1);
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
            sif.fgi = hold;
        end
    end

    // Drive one frame; rst_at >= 0 asserts reset half-way through that bit
    // (0 = start, 1..8 = data bits) and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic par_v, input int rst_at);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef SERIAL_IN_PARITY_EN
        bits[9] = par_v;
        bits[10] = stop_v;
        nb = 11;
`else
        bits[9] = stop_v;
        nb = 10;
        if (par_v) nb = 10;
`endif
        for (int k = 0; k < nb; k++) begin
            sif.uart_rxd = bits[k];
            if (k == rst_at) begin
                repeat (BAUD / 2) @(negedge clk);
                rst = 1'b1;
                sif.uart_rxd = 1'b1;
                return;
            end
            repeat (BAUD) @(negedge clk);
        end
        sif.uart_rxd = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    // Model: a frame is accepted only with a good stop bit (and good parity
    // when enabled); an accepted byte is lost if DEPTH bytes are already waiting.
    task automatic send_byte(input logic [7:0] d, input logic stop_v, input logic par_v);
        logic good;
        good = stop_v;
`ifdef SERIAL_IN_PARITY_EN
        if (par_v != ^d) good = 1'b0;
`endif
        if (!good) exp_err = 1'b1;
        else if (exp_q.size() - got_q.size() >= DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back(d);
        send_frame(d, stop_v, par_v, -1);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_byte(d, 1'b1, ^d);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_byte"}, {24'b0, got_q[i]}, {24'b0, exp_q[i]});
        chk({tag, "_err"}, {31'b0, sif.rx_err}, {31'b0, exp_err});
        chk({tag, "_ovf"}, {31'b0, sif.rx_ovf}, {31'b0, exp_ovf});
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_fgi_bsy"}, {31'b0, sif.fgi_bsy}, 32'd1);
        chk({tag, "_inpr"}, {24'b0, sif.inpr}, 32'd0);
        chk({tag, "_err"}, {31'b0, sif.rx_err}, 32'd0);
        chk({tag, "_ovf"}, {31'b0, sif.rx_ovf}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        sif.uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals(tag);
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        hold = 1'b0;
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        sif.uart_rxd = 1'b1;
        rst = 1'b1;

        // Reset state.
        do_reset("reset");

        // T1: single byte with CPU ready.
        send_good(8'h41);
        drain("t1");

        // T5: short low glitch must not start a frame.
        sif.uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        sif.uart_rxd = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        drain("t5");

        // T2: eight bytes buffered while FGI held, then released.
        hold = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) send_good(8'h31 + 8'(i));
        chk("t2_no_strobe", got_q.size(), 32'd0);
        hold = 1'b0;
        drain("t2");

        // T3: nine bytes into a full FIFO; the ninth is lost.
        hold = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) send_good(8'($urandom));
        chk("t3_no_strobe", got_q.size(), 32'd0);
        chk("t3_ovf_early", {31'b0, sif.rx_ovf}, 32'd1);
        hold = 1'b0;
        drain("t3");

        // Random bytes with random idle gaps and a free-running CPU.
        for (int i = 0; i < 6; i++) begin
            send_good(8'($urandom));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        drain("rand");

        // T6: reset mid-frame discards buffered bytes and the partial frame.
        hold = 1'b1;
        repeat (3) @(negedge clk);
        send_good(8'h11);
        send_good(8'h22);
        send_frame(8'hF0, 1'b1, ^8'hF0, 5);
        @(negedge clk);
        check_reset_vals("t6_in_rst");
        hold = 1'b0;
        do_reset("t6");
        repeat (50) @(negedge clk);
        chk("t6_discarded", got_q.size(), 32'd0);
        send_good(8'h0F);
        drain("t6_after");

`ifdef SERIAL_IN_PARITY_EN
        // T7: wrong even parity drops the byte; correct parity delivers it.
        send_byte(8'h03, 1'b1, 1'b1);
        send_byte(8'h03, 1'b1, 1'b0);
        drain("t7");
        do_reset("t7_rst");
`endif

        // T4: stop bit low is a framing error; next good frame still delivered.
        send_byte(8'h55, 1'b0, ^8'h55);
        chk("t4_no_strobe", got_q.size(), 32'd0);
        chk("t4_err", {31'b0, sif.rx_err}, 32'd1);
        send_good(8'hAA);
        drain("t4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
